ccu_snoop_fanout: RTL and testbench

- Sits directly downstream of the CCU write/read snoop controllers' snoop port, between a single snoop initiator and NoMstPorts cached masters.
- Broadcasts one AC request to every cached master selected by the domain mask.
- Collects all CR responses and merges them into one CR response.
- Forwards exactly one CD burst upstream and drains and discards every other CD burst.

---
 rtl/ccu_snoop_fanout_pkg.sv | 51 +++++
 rtl/ccu_cr_merge.sv | 51 +++++
 rtl/ccu_snoop_fanout.sv | 186 ++++++++++++++++++
 tb/tb_ccu_snoop_fanout.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ccu_snoop_fanout_pkg.sv
// Shared types for the CCU snoop fan-out: snoop channel structs, FSM states
// and the CR response merge helper.
package ccu_snoop_fanout_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  snoop;
    logic [2:0]  prot;
  } ac_chan_t;

  // Field order mirrors CRRESP[4:0]: WasUnique, IsShared, PassDirty, Error, DataTransfer.
  typedef struct packed {
    logic was_unique;
    logic is_shared;
    logic pass_dirty;
    logic error;
    logic data_transfer;
  } cr_resp_t;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } cd_chan_t;

  typedef struct packed {
    logic     ac_valid;
    ac_chan_t ac;
    logic     cr_ready;
    logic     cd_ready;
  } snoop_req_t;

  typedef struct packed {
    logic     ac_ready;
    logic     cr_valid;
    cr_resp_t cr_resp;
    logic     cd_valid;
    cd_chan_t cd;
  } snoop_resp_t;

  typedef enum logic [1:0] {StIdle, StCrCollect, StCrResp, StCdFwd} ccu_fanout_state_e;

  // OR-reduced fields come from `ored`; PassDirty is taken from the selected
  // data source and only when some master transfers data.
  function automatic cr_resp_t crresp_merge(input cr_resp_t ored, input cr_resp_t sel_resp);
    cr_resp_t r;
    r            = ored;
    r.pass_dirty = ored.data_transfer & sel_resp.pass_dirty;
    return r;
  endfunction

endpackage

// File: rtl/ccu_cr_merge.sv
// Combinational merge of the stored per-master CR responses: picks the CD
// source, the set of CD bursts to drain and the merged upstream response.
module ccu_cr_merge
  import ccu_snoop_fanout_pkg::*;
#(
  parameter int unsigned NoMstPorts = 4,
  parameter int unsigned IdxW       = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1
) (
  input  cr_resp_t                cr_i [NoMstPorts],
  input  logic [NoMstPorts-1:0]   tgt_i,
  output cr_resp_t                resp_o,
  output logic [IdxW-1:0]         sel_o,
  output logic [NoMstPorts-1:0]   drain_o
);

  cr_resp_t ored;
  logic     found_pd;
  logic     found_dt;

  // Prefer the lowest clean dirty owner, else the lowest master sending data.
  always_comb begin
    ored     = '0;
    sel_o    = '0;
    found_pd = 1'b0;
    found_dt = 1'b0;
    drain_o  = '0;
    for (int i = 0; i < NoMstPorts; i++) begin
      if (tgt_i[i]) ored = cr_resp_t'(ored | cr_i[i]);
    end
    for (int i = 0; i < NoMstPorts; i++) begin
      if (tgt_i[i] && cr_i[i].data_transfer && cr_i[i].pass_dirty && !cr_i[i].error &&
          !found_pd) begin
        sel_o    = IdxW'(i);
        found_pd = 1'b1;
      end
    end
    if (!found_pd) begin
      for (int i = 0; i < NoMstPorts; i++) begin
        if (tgt_i[i] && cr_i[i].data_transfer && !found_dt) begin
          sel_o    = IdxW'(i);
          found_dt = 1'b1;
        end
      end
    end
    resp_o = crresp_merge(ored, cr_i[sel_o]);
    for (int i = 0; i < NoMstPorts; i++) begin
      drain_o[i] = tgt_i[i] & cr_i[i].data_transfer & (IdxW'(i) != sel_o);
    end
  end

endmodule

// File: rtl/ccu_snoop_fanout.sv
// Snoop fan-out: broadcasts one AC to the masked cached masters, merges their
// CR responses and forwards a single CD burst while draining the others.
module ccu_snoop_fanout
  import ccu_snoop_fanout_pkg::*;
#(
  parameter int unsigned NoMstPorts       = 4,
  parameter int unsigned DataBeats        = 4,
  parameter type         mst_snoop_req_t  = snoop_req_t,
  parameter type         mst_snoop_resp_t = snoop_resp_t,
  parameter type         domain_mask_t    = logic [NoMstPorts-1:0]
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  mst_snoop_req_t  slv_snoop_req_i,
  output mst_snoop_resp_t slv_snoop_resp_o,
  input  domain_mask_t    domain_mask_i,
  output mst_snoop_req_t  mst_snoop_req_o [NoMstPorts],
  input  mst_snoop_resp_t mst_snoop_resp_i [NoMstPorts]
);

  localparam int unsigned IdxW = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1;

  if (NoMstPorts < 1) begin : g_bad_ports
    $error("NoMstPorts must be at least 1");
  end
  if (DataBeats < 1) begin : g_bad_beats
    $error("DataBeats must be at least 1");
  end

  ccu_fanout_state_e     state_q, state_d;
  logic [NoMstPorts-1:0] sent_q, sent_d, got_q, got_d, tgt_q, tgt_d;
  logic [NoMstPorts-1:0] drain_q, drain_d, drained_q, drained_d;
  logic [IdxW-1:0]       sel_q, sel_d;
  logic                  sel_done_q, sel_done_d;
  cr_resp_t              merged_q, merged_d;
  cr_resp_t              cr_q [NoMstPorts];
  cr_resp_t              cr_d [NoMstPorts];

  cr_resp_t              mrg_resp;
  logic [IdxW-1:0]       mrg_sel;
  logic [NoMstPorts-1:0] mrg_drain;
  logic [NoMstPorts-1:0] ac_hs;
  logic                  clear;

  ccu_cr_merge #(
    .NoMstPorts (NoMstPorts),
    .IdxW       (IdxW)
  ) u_cr_merge (
    .cr_i    (cr_q),
    .tgt_i   (tgt_q),
    .resp_o  (mrg_resp),
    .sel_o   (mrg_sel),
    .drain_o (mrg_drain)
  );

  // Next-state and handshake logic for the four transaction phases.
  always_comb begin
    state_d          = state_q;
    sent_d           = sent_q;
    got_d            = got_q;
    tgt_d            = tgt_q;
    drain_d          = drain_q;
    drained_d        = drained_q;
    sel_d            = sel_q;
    sel_done_d       = sel_done_q;
    merged_d         = merged_q;
    cr_d             = cr_q;
    ac_hs            = '0;
    clear            = 1'b0;
    slv_snoop_resp_o = '0;
    for (int i = 0; i < NoMstPorts; i++) begin
      mst_snoop_req_o[i]    = '0;
      mst_snoop_req_o[i].ac = slv_snoop_req_i.ac;
    end

    unique case (state_q)
      StIdle: begin
        if (slv_snoop_req_i.ac_valid) begin
          for (int i = 0; i < NoMstPorts; i++) begin
            mst_snoop_req_o[i].ac_valid = domain_mask_i[i] & ~sent_q[i];
            ac_hs[i] = mst_snoop_req_o[i].ac_valid & mst_snoop_resp_i[i].ac_ready;
          end
          sent_d = sent_q | ac_hs;
          // Accept upstream once every selected port has taken the request.
          if (((sent_q | ac_hs) & domain_mask_i) == domain_mask_i) begin
            slv_snoop_resp_o.ac_ready = 1'b1;
            tgt_d   = domain_mask_i;
            sent_d  = '0;
            got_d   = '0;
            for (int i = 0; i < NoMstPorts; i++) cr_d[i] = '0;
            state_d = StCrCollect;
          end
        end
      end
      StCrCollect: begin
        for (int i = 0; i < NoMstPorts; i++) begin
          mst_snoop_req_o[i].cr_ready = tgt_q[i] & ~got_q[i];
          if (mst_snoop_req_o[i].cr_ready && mst_snoop_resp_i[i].cr_valid) begin
            cr_d[i]  = mst_snoop_resp_i[i].cr_resp;
            got_d[i] = 1'b1;
          end
        end
        if (got_q == tgt_q) begin
          merged_d = mrg_resp;
          sel_d    = mrg_sel;
          drain_d  = mrg_drain;
          state_d  = StCrResp;
        end
      end
      StCrResp: begin
        slv_snoop_resp_o.cr_valid = 1'b1;
        slv_snoop_resp_o.cr_resp  = merged_q;
        if (slv_snoop_req_i.cr_ready) begin
          if (merged_q.data_transfer) begin
            state_d = StCdFwd;
          end else begin
            state_d = StIdle;
            clear   = 1'b1;
          end
        end
      end
      StCdFwd: begin
        slv_snoop_resp_o.cd       = mst_snoop_resp_i[sel_q].cd;
        slv_snoop_resp_o.cd_valid = mst_snoop_resp_i[sel_q].cd_valid & ~sel_done_q;
        for (int i = 0; i < NoMstPorts; i++) begin
          if (IdxW'(i) == sel_q) begin
            mst_snoop_req_o[i].cd_ready = slv_snoop_req_i.cd_ready & ~sel_done_q;
          end else begin
            // Drained beats are accepted and dropped.
            mst_snoop_req_o[i].cd_ready = drain_q[i] & ~drained_q[i];
            if (mst_snoop_req_o[i].cd_ready && mst_snoop_resp_i[i].cd_valid &&
                mst_snoop_resp_i[i].cd.last) begin
              drained_d[i] = 1'b1;
            end
          end
        end
        if (slv_snoop_resp_o.cd_valid && slv_snoop_req_i.cd_ready &&
            mst_snoop_resp_i[sel_q].cd.last) begin
          sel_done_d = 1'b1;
        end
        if (sel_done_d && (drained_d == drain_q)) begin
          state_d = StIdle;
          clear   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (clear) begin
      sent_d     = '0;
      got_d      = '0;
      tgt_d      = '0;
      drain_d    = '0;
      drained_d  = '0;
      sel_done_d = 1'b0;
    end
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      sent_q     <= '0;
      got_q      <= '0;
      tgt_q      <= '0;
      drain_q    <= '0;
      drained_q  <= '0;
      sel_q      <= '0;
      sel_done_q <= 1'b0;
      merged_q   <= '0;
      for (int i = 0; i < NoMstPorts; i++) cr_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      sent_q     <= sent_d;
      got_q      <= got_d;
      tgt_q      <= tgt_d;
      drain_q    <= drain_d;
      drained_q  <= drained_d;
      sel_q      <= sel_d;
      sel_done_q <= sel_done_d;
      merged_q   <= merged_d;
      for (int i = 0; i < NoMstPorts; i++) cr_q[i] <= cr_d[i];
    end
  end

endmodule

// File: tb/tb_ccu_snoop_fanout.sv
// Directed bench for ccu_snoop_fanout: table of snoop transactions against
// reactive master models, a follow-up mask=0 probe per row, and a mid-burst reset.
module tb_ccu_snoop_fanout;
  import ccu_snoop_fanout_pkg::*;

  localparam int N = 4;

  typedef struct packed {
    logic [N-1:0]      mask;
    logic [N-1:0][3:0] ac_dly;
    cr_resp_t [N-1:0]  cr;
    logic [N-1:0][1:0] stall;
    logic              up_stall;
    cr_resp_t          exp_resp;
    logic [1:0]        exp_sel;
    logic [3:0]        exp_beats;
    logic [3:0]        exp_ac_cyc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  snoop_req_t  up_req;
  snoop_resp_t up_resp;
  logic [N-1:0] mask;
  snoop_req_t  m_req [N];
  snoop_resp_t m_resp [N];

  int n_tests = 0;
  int n_fail  = 0;

  int ac_cnt [N];
  int cd_cnt [N];
  int last_rel [N];
  int cr_hs_rel [N];
  bit cr_pend [N];
  bit cd_pend [N];
  bit cd_up [N];

  vec_t vecs [6];

  always #5 clk = ~clk;

  ccu_snoop_fanout #(
    .NoMstPorts (N),
    .DataBeats  (4)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .slv_snoop_req_i  (up_req),
    .slv_snoop_resp_o (up_resp),
    .domain_mask_i    (mask),
    .mst_snoop_req_o  (m_req),
    .mst_snoop_resp_i (m_resp)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int count_active();
    int c;
    c = int'(up_resp.ac_ready) + int'(up_resp.cr_valid) + int'(up_resp.cd_valid);
    for (int i = 0; i < N; i++) begin
      c += int'(m_req[i].ac_valid) + int'(m_req[i].cr_ready) + int'(m_req[i].cd_ready);
    end
    return c;
  endfunction

  task automatic idle_inputs();
    up_req = '0;
    mask   = '0;
    for (int i = 0; i < N; i++) m_resp[i] = '0;
  endtask

  // One full transaction followed by a mask=0 probe; abort_at>0 asserts reset
  // once that many upstream CD beats have been forwarded.
  task automatic run_txn(input string tag, input vec_t v, input int abort_at);
    int       rel, acc_rel, up_cr_rel, up_beats, bad_beats, ac_bad;
    int       probe_acc_rel, probe_cr_rel, mcr_last, done_rel;
    bit       acc_main, got_cr, up_last_seen, probe_acc, probe_cr_seen, main_done;
    cr_resp_t up_cr, probe_cr;
    logic [4*N-1:0] cnt_act, cnt_exp, beat_act, beat_exp;

    acc_main = 0; got_cr = 0; up_last_seen = 0; probe_acc = 0; probe_cr_seen = 0;
    acc_rel = -1; up_cr_rel = -1; up_beats = 0; bad_beats = 0; ac_bad = 0;
    probe_acc_rel = -1; probe_cr_rel = -1; up_cr = '0; probe_cr = '0;
    for (int i = 0; i < N; i++) begin
      ac_cnt[i] = 0; cd_cnt[i] = 0; last_rel[i] = -1; cr_hs_rel[i] = -1;
      cr_pend[i] = 0; cd_pend[i] = 0; cd_up[i] = 0;
    end

    for (rel = 0; rel < 300 && !probe_cr_seen; rel++) begin
      @(negedge clk);
      if (abort_at > 0 && up_beats == abort_at) begin
        up_req.ac_valid = 1'b0;
        rst_ni = 1'b0;
        #1;
        check({tag, " reset_outputs"}, 64'(count_active()), 64'd0);
        idle_inputs();
        return;
      end
      main_done = got_cr && (!up_cr.data_transfer || up_last_seen);
      up_req.ac_valid  = !acc_main || (main_done && !probe_acc);
      up_req.ac.addr   = 32'hC0DE_0000 | 32'(rel);
      up_req.ac.snoop  = 4'h7;
      up_req.ac.prot   = 3'h2;
      mask             = !acc_main ? v.mask : '0;
      up_req.cr_ready  = 1'b1;
      up_req.cd_ready  = v.up_stall ? rel[0] : 1'b1;
      for (int i = 0; i < N; i++) begin
        m_resp[i].ac_ready = (rel >= int'(v.ac_dly[i]));
        m_resp[i].cr_valid = cr_pend[i];
        m_resp[i].cr_resp  = v.cr[i];
        if (cd_pend[i] && (rel % (int'(v.stall[i]) + 1) == 0)) cd_up[i] = 1;
        m_resp[i].cd_valid = cd_up[i];
        m_resp[i].cd.data  = {32'(i), 32'(cd_cnt[i])};
        m_resp[i].cd.last  = (cd_cnt[i] == 3);
      end
      #1;
      for (int i = 0; i < N; i++) begin
        if (m_req[i].ac_valid) begin
          if (m_req[i].ac !== up_req.ac) ac_bad++;
          if (m_resp[i].ac_ready) begin
            ac_cnt[i]++;
            cr_pend[i] = 1;
          end
        end
        if (m_resp[i].cr_valid && m_req[i].cr_ready) begin
          cr_pend[i]   = 0;
          cr_hs_rel[i] = rel;
          cd_pend[i]   = v.cr[i].data_transfer;
        end
        if (m_resp[i].cd_valid && m_req[i].cd_ready) begin
          cd_up[i] = 0;
          if (m_resp[i].cd.last) begin
            cd_pend[i]  = 0;
            last_rel[i] = rel;
          end
          cd_cnt[i]++;
        end
      end
      if (up_req.ac_valid && up_resp.ac_ready) begin
        if (!acc_main) begin
          acc_main = 1; acc_rel = rel;
        end else begin
          probe_acc = 1; probe_acc_rel = rel;
        end
      end
      if (up_resp.cr_valid && up_req.cr_ready) begin
        if (!got_cr) begin
          got_cr = 1; up_cr = up_resp.cr_resp; up_cr_rel = rel;
        end else begin
          probe_cr_seen = 1; probe_cr = up_resp.cr_resp; probe_cr_rel = rel;
        end
      end
      if (up_resp.cd_valid && up_req.cd_ready) begin
        if (up_resp.cd.data !== {32'(v.exp_sel), 32'(up_beats)} ||
            up_resp.cd.last !== (up_beats == 3)) bad_beats++;
        if (up_resp.cd.last) up_last_seen = 1;
        up_beats++;
      end
    end
    @(negedge clk);
    idle_inputs();

    mcr_last = acc_rel;
    done_rel = up_cr_rel;
    for (int i = 0; i < N; i++) begin
      if (v.mask[i] && cr_hs_rel[i] > mcr_last) mcr_last = cr_hs_rel[i];
      if (v.mask[i] && v.cr[i].data_transfer && last_rel[i] > done_rel) done_rel = last_rel[i];
      cnt_act[4*i +: 4]  = 4'(ac_cnt[i]);
      cnt_exp[4*i +: 4]  = {3'b0, v.mask[i]};
      beat_act[4*i +: 4] = 4'(cd_cnt[i]);
      beat_exp[4*i +: 4] = (v.mask[i] && v.cr[i].data_transfer) ? 4'd4 : 4'd0;
    end

    check({tag, " completed"},     64'(probe_cr_seen), 64'd1);
    check({tag, " ac_accept_cyc"}, 64'(acc_rel), 64'(v.exp_ac_cyc));
    check({tag, " ac_per_port"},   64'(cnt_act), 64'(cnt_exp));
    check({tag, " ac_fields"},     64'(ac_bad), 64'd0);
    check({tag, " cr_resp"},       64'(up_cr), 64'(v.exp_resp));
    check({tag, " cr_latency"},    64'(up_cr_rel), 64'(mcr_last + 2));
    check({tag, " up_beats"},      64'(up_beats), 64'(v.exp_beats));
    check({tag, " beat_data"},     64'(bad_beats), 64'd0);
    check({tag, " mst_beats"},     64'(beat_act), 64'(beat_exp));
    check({tag, " idle_after"},    64'(probe_acc_rel), 64'(done_rel + 1));
    check({tag, " probe_resp"},    64'(probe_cr), 64'd0);
    check({tag, " probe_latency"}, 64'(probe_cr_rel), 64'(probe_acc_rel + 2));
  endtask

  initial begin
    idle_inputs();
    // cr fields: {WasUnique, IsShared, PassDirty, Error, DataTransfer}
    vecs[0] = '0; vecs[0].mask = 4'b0110; vecs[0].ac_dly[1] = 4'd2; vecs[0].ac_dly[2] = 4'd4;
    vecs[0].cr[1] = 5'b00101; vecs[0].cr[2] = 5'b01000;
    vecs[0].exp_resp = 5'b01101; vecs[0].exp_sel = 2'd1; vecs[0].exp_beats = 4'd4;
    vecs[0].exp_ac_cyc = 4'd4;

    vecs[1] = '0; vecs[1].mask = 4'b0110; vecs[1].cr[1] = 5'b00001; vecs[1].cr[2] = 5'b00101;
    vecs[1].stall[1] = 2'd2;
    vecs[1].exp_resp = 5'b00101; vecs[1].exp_sel = 2'd2; vecs[1].exp_beats = 4'd4;
    vecs[1].exp_ac_cyc = 4'd0;

    vecs[2] = '0;

    vecs[3] = '0; vecs[3].mask = 4'b1001; vecs[3].ac_dly[0] = 4'd1; vecs[3].ac_dly[3] = 4'd3;
    vecs[3].cr[0] = 5'b00111; vecs[3].cr[3] = 5'b00101; vecs[3].up_stall = 1'b1;
    vecs[3].exp_resp = 5'b00111; vecs[3].exp_sel = 2'd3; vecs[3].exp_beats = 4'd4;
    vecs[3].exp_ac_cyc = 4'd3;

    vecs[4] = '0; vecs[4].mask = 4'b1111;
    vecs[4].ac_dly[0] = 4'd3; vecs[4].ac_dly[1] = 4'd1; vecs[4].ac_dly[3] = 4'd2;
    vecs[4].cr[0] = 5'b10000; vecs[4].cr[1] = 5'b01000; vecs[4].cr[3] = 5'b01000;
    vecs[4].exp_resp = 5'b11000; vecs[4].exp_ac_cyc = 4'd3;

    vecs[5] = '0; vecs[5].mask = 4'b0101; vecs[5].ac_dly[2] = 4'd1; vecs[5].stall[0] = 2'd1;
    vecs[5].cr[0] = 5'b00001; vecs[5].cr[2] = 5'b00001;
    vecs[5].exp_resp = 5'b00001; vecs[5].exp_sel = 2'd0; vecs[5].exp_beats = 4'd4;
    vecs[5].exp_ac_cyc = 4'd1;

    @(negedge clk);
    check("reset_state", 64'(count_active()), 64'd0);
    rst_ni = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 64'(count_active()), 64'd0);

    for (int r = 0; r < 6; r++) begin
      run_txn($sformatf("row%0d", r), vecs[r], 0);
    end

    // Reset during the second forwarded beat, then a fresh transaction.
    run_txn("abort", vecs[0], 1);
    repeat (2) @(negedge clk);
    check("held_reset_outputs", 64'(count_active()), 64'd0);
    rst_ni = 1'b1;
    run_txn("post_reset", vecs[0], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
